// File: rtl/mem_wb_stage_pkg.sv
// Shared types and encodings for the MEM/WB pipeline boundary.
// Holds load funct3 codes, writeback selects and the registered control record.
package mem_wb_stage_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] WB_SEL_LD  = 2'd0;
    localparam logic [1:0] WB_SEL_ALU = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // Datapath fields are XLEN-parameterised in the stage, so the record carries control only.
    typedef struct packed {
        logic       valid;
        logic [1:0] wb_en;
        logic [4:0] rd_addr;
        logic       rd_wren;
        logic       ld_misalign;
    } mem_wb_t;

    localparam mem_wb_t WB_BUBBLE = '{
        valid:       1'b0,
        wb_en:       WB_SEL_ALU,
        rd_addr:     5'd0,
        rd_wren:     1'b0,
        ld_misalign: 1'b0
    };

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword, extends it,
// and flags misaligned halfword/word loads. Unknown funct3 behaves as lw.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      off,
    input  logic [2:0]      ld_type,
    input  logic            is_load,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = raw[{off, 3'b000} +: 8];
    assign half_s = raw[{off[1], 4'b0000} +: 16];

    // Extend the selected lane and detect misalignment.
    always_comb begin
        data     = raw;
        misalign = 1'b0;
        case (ld_type)
            LD_LB: begin
                data     = {{(XLEN-8){byte_s[7]}}, byte_s};
                misalign = 1'b0;
            end
            LD_LBU: begin
                data     = {{(XLEN-8){1'b0}}, byte_s};
                misalign = 1'b0;
            end
            LD_LH: begin
                data     = {{(XLEN-16){half_s[15]}}, half_s};
                misalign = off[0];
            end
            LD_LHU: begin
                data     = {{(XLEN-16){1'b0}}, half_s};
                misalign = off[0];
            end
            default: begin
                data     = raw;
                misalign = (off != 2'b00);
            end
        endcase
        if (!is_load) begin
            misalign = 1'b0;
        end else begin
            misalign = misalign;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, bubble/stall handling
// and a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MEM_valid,
    input  logic [XLEN-1:0]  MEM_ld_raw,
    input  logic [XLEN-1:0]  MEM_alu_data,
    input  logic [XLEN-1:0]  MEM_pc_four,
    input  logic [2:0]       MEM_ld_type,
    input  logic             MEM_is_load,
    input  logic [1:0]       MEM_wb_en,
    input  logic [4:0]       MEM_rd_addr,
    input  logic             MEM_rd_wren,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             WB_valid,
    output logic [XLEN-1:0]  WB_ld_data,
    output logic [XLEN-1:0]  WB_alu_data,
    output logic [XLEN-1:0]  WB_pc_four,
    output logic [1:0]       WB_wb_en,
    output logic [4:0]       WB_rd_addr,
    output logic             WB_rd_wren,
    output logic             WB_ld_misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [XLEN-1:0] aligned_s;
    logic            misalign_s;

    mem_wb_t         ctrl_r,    ctrl_nxt_s;
    logic [XLEN-1:0] ld_r,      ld_nxt_s;
    logic [XLEN-1:0] alu_r,     alu_nxt_s;
    logic [XLEN-1:0] pc4_r,     pc4_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic            retire_s;

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw      (MEM_ld_raw),
        .off      (MEM_alu_data[1:0]),
        .ld_type  (MEM_ld_type),
        .is_load  (MEM_is_load),
        .data     (aligned_s),
        .misalign (misalign_s)
    );

    // Select the next stage contents: flush beats stall beats capture.
    always_comb begin
        ctrl_nxt_s = WB_BUBBLE;
        ld_nxt_s   = '0;
        alu_nxt_s  = '0;
        pc4_nxt_s  = '0;
        if (flush_i) begin
            ctrl_nxt_s = WB_BUBBLE;
        end else if (stall_i) begin
            ctrl_nxt_s = ctrl_r;
            ld_nxt_s   = ld_r;
            alu_nxt_s  = alu_r;
            pc4_nxt_s  = pc4_r;
        end else if (!MEM_valid) begin
            ctrl_nxt_s = WB_BUBBLE;
        end else begin
            ctrl_nxt_s.valid       = 1'b1;
            ctrl_nxt_s.wb_en       = MEM_wb_en;
            ctrl_nxt_s.rd_addr     = MEM_rd_addr;
            ctrl_nxt_s.rd_wren     = MEM_rd_wren && (MEM_rd_addr != 5'd0) && !misalign_s;
            ctrl_nxt_s.ld_misalign = misalign_s;
            ld_nxt_s               = misalign_s ? '0 : aligned_s;
            alu_nxt_s              = MEM_alu_data;
            pc4_nxt_s              = MEM_pc_four;
        end
    end

    // An instruction retires as it leaves WB, unless it faulted or WB is held.
    assign retire_s = ctrl_r.valid && !ctrl_r.ld_misalign && !stall_i;

    // Stage register and retire counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_r <= WB_BUBBLE;
            ld_r   <= '0;
            alu_r  <= '0;
            pc4_r  <= '0;
            cnt_r  <= '0;
        end else begin
            ctrl_r <= ctrl_nxt_s;
            ld_r   <= ld_nxt_s;
            alu_r  <= alu_nxt_s;
            pc4_r  <= pc4_nxt_s;
            if (retire_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign WB_valid       = ctrl_r.valid;
    assign WB_ld_data     = ld_r;
    assign WB_alu_data    = alu_r;
    assign WB_pc_four     = pc4_r;
    assign WB_wb_en       = ctrl_r.wb_en;
    assign WB_rd_addr     = ctrl_r.rd_addr;
    assign WB_rd_wren     = ctrl_r.rd_wren;
    assign WB_ld_misalign = ctrl_r.ld_misalign;
    assign retire_cnt     = cnt_r;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
- REQ-001 SHALL have one clock; reset is synchronous and active-high.
- REQ-002 Parameter: XLEN, default 32, datapath width.
- REQ-003 Parameter: CNT_W, default 32, retire-counter width.
- REQ-004 clk_i  in  1  stage clock; all state changes on rising edge.
- REQ-005 rst_i  in  1  synchronous active-high reset.
- REQ-006 MEM_valid  in  1  MEM stage holds a real instruction.
- REQ-007 MEM_ld_raw  in  XLEN  raw word read from data memory (word-aligned).
- REQ-008 MEM_alu_data  in  XLEN  ALU result; bits [1:0] are the byte offset.
- REQ-009 MEM_pc_four  in  XLEN  PC+4 of the instruction.
- REQ-010 MEM_ld_type  in  3  load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- REQ-011 MEM_is_load  in  1  instruction is a load.
- REQ-012 MEM_wb_en  in  2  writeback select (0 load, 1 ALU, 2 PC+4).
- REQ-013 MEM_rd_addr  in  5  destination register.
- REQ-014 MEM_rd_wren  in  1  destination write enable.
- REQ-015 stall_i  in  1  hold the stage contents.
- REQ-016 flush_i  in  1  replace incoming instruction with a bubble.
- REQ-017 WB_valid, WB_ld_data, WB_alu_data, WB_pc_four, WB_wb_en, WB_rd_addr, WB_rd_wren  out  (widths as the inputs)  registered stage outputs.
- REQ-018 WB_ld_misalign  out  1  registered load-misalignment flag.
- REQ-019 retire_cnt  out  CNT_W  count of retired valid instructions.

Function
- REQ-020 SHALL align and extend loads combinationally before the register: lb/lbu select byte [8*off+7:8*off]; lh/lhu select halfword [16*off[1]+15:16*off[1]]; sign-extend for lb/lh, zero-extend for lbu/lhu; lw passes the word.
- REQ-021 SHALL treat an undefined MEM_ld_type as lw.
- REQ-022 SHALL compute misalignment as a load with (lh/lhu and off[0]=1) or (lw and off!=0).
- REQ-023 On a misaligned load SHALL register WB_ld_misalign=1, force WB_rd_wren=0 and WB_ld_data=0.
- REQ-024 Latency SHALL be exactly 1 cycle from MEM inputs to WB outputs when there is no stall and no flush.
- REQ-025 Priority SHALL be rst_i > flush_i > stall_i > normal capture.
- REQ-026 flush_i=1 SHALL load a bubble: WB_valid=0, WB_rd_wren=0, WB_ld_misalign=0, data fields 0, WB_wb_en=1.
- REQ-027 stall_i=1 without flush SHALL hold all WB outputs unchanged.
- REQ-028 MEM_valid=0 on capture SHALL produce a bubble identical to REQ-026.
- REQ-029 WB_rd_wren SHALL be 0 whenever MEM_rd_addr=0.
- REQ-030 retire_cnt SHALL increment by 1 on each edge where WB_valid=1, WB_ld_misalign=0 and stall_i=0.
- REQ-031 retire_cnt SHALL wrap modulo 2^CNT_W with no saturation.
- REQ-032 MEM_wb_en=3 SHALL pass through unmodified.

Reset
- REQ-033 On rst_i=1 at a clock edge, all WB_* outputs SHALL be 0 except WB_wb_en=1, and retire_cnt SHALL be 0.
- REQ-034 Reset asserted mid-stall or mid-flush SHALL override both; outputs SHALL follow REQ-033 on the next edge.

Structure
- REQ-035 The shared package SHALL hold the load funct3 constants, the wb_en encodings (WB_SEL_LD/ALU/PC4) and a mem_wb_t struct for the registered fields.
- REQ-036 The load aligner SHALL be a separate combinational sub-module named load_align.

Verification
- REQ-037 Scenario: MEM_ld_raw=0x80FF7F01, off=1, lb -> WB_ld_data=0x0000007F one cycle later; lbu off=3 -> 0x00000080; lb off=3 -> 0xFFFFFF80.
- REQ-038 Scenario: lh, off=2, raw=0x8001xxxx -> WB_ld_data=0xFFFF8001; lhu -> 0x00008001.
- REQ-039 Scenario: lw, alu_data=0x1002, rd=5, wren=1 -> WB_ld_misalign=1, WB_rd_wren=0, retire_cnt unchanged.
- REQ-040 Scenario: stall_i=1 for 3 cycles with changing inputs -> WB outputs and retire_cnt frozen; release -> new capture next edge.
- REQ-041 Scenario: flush_i=1 together with stall_i=1 -> bubble (WB_valid=0, WB_rd_wren=0, WB_wb_en=1).
- REQ-042 Scenario: preload retire_cnt to 0xFFFFFFFF via 2^32-1 retirements (forced) then one valid retire -> retire_cnt=0; rst_i mid-stream -> all outputs per REQ-033.
